// File: rtl/accel_csr_responder.sv
// CSR responder for one accelerator register window: base registers, start kick, job tracking with timeout.
// Optional interrupt output is enabled by defining ACCEL_IRQ_EN.
module accel_csr_responder #(
    parameter int                ADDR_W   = 19,
    parameter int                DATA_W   = 19,
    parameter logic [ADDR_W-1:0] BASE     = 19'h70000,
    parameter int                WIN_BITS = 3,
    parameter int                TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_valid,
    input  logic              bus_write,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              acc_start,
    output logic [ADDR_W-1:0] acc_in_base,
    output logic [ADDR_W-1:0] acc_out_base,
    input  logic              acc_done,
    output logic              irq
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [WIN_BITS-1:0] OFF_CTRL   = WIN_BITS'(0);
    localparam logic [WIN_BITS-1:0] OFF_STATUS = WIN_BITS'(1);
    localparam logic [WIN_BITS-1:0] OFF_IN     = WIN_BITS'(2);
    localparam logic [WIN_BITS-1:0] OFF_OUT    = WIN_BITS'(3);
    localparam logic [WIN_BITS-1:0] OFF_CYCLES = WIN_BITS'(4);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d;
    logic [ADDR_W-1:0] out_base_q, out_base_d;
    logic              cmd_err_q, cmd_err_d;
    logic              timeout_q, timeout_d;
    logic              acc_start_q, acc_start_d;
`ifdef ACCEL_IRQ_EN
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
`endif

    logic                sel, wr, rd, start_wr, busy, done;
    logic [WIN_BITS-1:0] off;
    logic [ADDR_W-1:0]   wdata_a;
    logic [DATA_W-1:0]   status_v, ctrl_v, in_v, out_v, cycles_v;

    // Zero-extend or truncate between bus data and address widths without width warnings.
    logic [ADDR_W+DATA_W-1:0] wdata_ext, in_ext, out_ext;
    logic [CNT_W+DATA_W-1:0]  cyc_ext;

    assign sel      = bus_valid && (bus_addr[ADDR_W-1:WIN_BITS] == BASE[ADDR_W-1:WIN_BITS]);
    assign off      = bus_addr[WIN_BITS-1:0];
    assign wr       = sel && bus_write;
    assign rd       = sel && !bus_write;
    assign start_wr = wr && (off == OFF_CTRL) && bus_wdata[0];
    assign busy     = (state_q == S_START) || (state_q == S_RUN);
    assign done     = (state_q == S_DONE);

    assign wdata_ext = {{ADDR_W{1'b0}}, bus_wdata};
    assign wdata_a   = wdata_ext[ADDR_W-1:0];
    assign in_ext    = {{DATA_W{1'b0}}, in_base_q};
    assign out_ext   = {{DATA_W{1'b0}}, out_base_q};
    assign cyc_ext   = {{DATA_W{1'b0}}, cycles_q};
    assign in_v      = in_ext[DATA_W-1:0];
    assign out_v     = out_ext[DATA_W-1:0];
    assign cycles_v  = cyc_ext[DATA_W-1:0];

    always_comb begin
        status_v    = '0;
        status_v[0] = done;
        status_v[1] = busy;
        status_v[2] = cmd_err_q;
        status_v[3] = timeout_q;
        ctrl_v      = '0;
`ifdef ACCEL_IRQ_EN
        ctrl_v[1]   = irq_en_q;
`endif
    end

    always_comb begin
        bus_rdata = '0;
        if (rd) begin
            case (off)
                OFF_CTRL:   bus_rdata = ctrl_v;
                OFF_STATUS: bus_rdata = status_v;
                OFF_IN:     bus_rdata = in_v;
                OFF_OUT:    bus_rdata = out_v;
                OFF_CYCLES: bus_rdata = cycles_v;
                default:    bus_rdata = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cycles_d    = cycles_q;
        in_base_d   = in_base_q;
        out_base_d  = out_base_q;
        cmd_err_d   = cmd_err_q;
        timeout_d   = timeout_q;
        acc_start_d = 1'b0;
`ifdef ACCEL_IRQ_EN
        irq_en_d    = irq_en_q;
        irq_d       = 1'b0;
`endif

        // Clears are applied first so that any error set below in the same cycle wins.
        if (wr && off == OFF_STATUS) begin
            if (bus_wdata[2]) cmd_err_d = 1'b0;
            if (bus_wdata[3]) timeout_d = 1'b0;
        end
        if (wr && off == OFF_IN) begin
            if (busy) cmd_err_d = 1'b1;
            else      in_base_d = wdata_a;
        end
        if (wr && off == OFF_OUT) begin
            if (busy) cmd_err_d  = 1'b1;
            else      out_base_d = wdata_a;
        end
`ifdef ACCEL_IRQ_EN
        if (wr && off == OFF_CTRL) irq_en_d = bus_wdata[1];
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_wr) begin
                    state_d     = S_START;
                    acc_start_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            S_START: begin
                if (start_wr) cmd_err_d = 1'b1;
                if (acc_done) begin
                    state_d  = S_DONE;
                    cycles_d = '0;
                end else begin
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (start_wr) cmd_err_d = 1'b1;
                if (acc_done) begin
                    state_d  = S_DONE;
                    cycles_d = cnt_q + CNT_ONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    cycles_d  = CNT_MAX;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ACCEL_IRQ_EN
        irq_d = irq_en_d && (state_q == S_DONE) && !start_wr;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cycles_q    <= '0;
            in_base_q   <= '0;
            out_base_q  <= '0;
            cmd_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            acc_start_q <= 1'b0;
`ifdef ACCEL_IRQ_EN
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cycles_q    <= cycles_d;
            in_base_q   <= in_base_d;
            out_base_q  <= out_base_d;
            cmd_err_q   <= cmd_err_d;
            timeout_q   <= timeout_d;
            acc_start_q <= acc_start_d;
`ifdef ACCEL_IRQ_EN
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
`endif
        end
    end

    assign acc_start    = acc_start_q;
    assign acc_in_base  = in_base_q;
    assign acc_out_base = out_base_q;
`ifdef ACCEL_IRQ_EN
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
